// File: rtl/rx_ctrl.sv
// Control/buffering layer in front of rx_module: deferred config apply,
// rx_done edge to FIFO push, show-ahead receive FIFO and sticky status.
module rx_ctrl #(
  parameter int MAX_UART_DATA_W  = 8,
  parameter int TOTAL_CONF_WIDTH = 5,
  parameter int FIFO_DEPTH       = 8,
  parameter int FIFO_PTR_W       = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_wr_i,
  input  logic [TOTAL_CONF_WIDTH-1:0] cfg_data_i,
  input  logic                        cfg_en_i,
  output logic                        cfg_pending_o,
  output logic                        cfg_ack_o,
  output logic                        rx_en_o,
  output logic [TOTAL_CONF_WIDTH-1:0] rx_conf_o,
  input  logic                        rx_done_i,
  input  logic                        rx_busy_i,
  input  logic                        rx_parity_err_i,
  input  logic                        rx_stop_err_i,
  input  logic [MAX_UART_DATA_W-1:0]  rx_data_i,
  input  logic                        rd_req_i,
  output logic                        rd_valid_o,
  output logic [MAX_UART_DATA_W-1:0]  rd_data_o,
  output logic [FIFO_PTR_W:0]         fifo_count_o,
  output logic                        fifo_full_o,
  output logic                        overflow_o,
  output logic                        parity_err_o,
  output logic                        stop_err_o,
  input  logic                        clr_err_i
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_IDLE = 2'd2,
    ST_APPLY     = 2'd3
  } state_t;

  localparam logic [FIFO_PTR_W:0]   DEPTH_C   = (FIFO_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [FIFO_PTR_W:0]   CNT_ONE_C = (FIFO_PTR_W+1)'(1);
  localparam logic [FIFO_PTR_W-1:0] PTR_ONE_C = FIFO_PTR_W'(1);

  state_t                        state_r, next_state_s;
  logic                          init_done_r;
  logic                          cfg_wr_s;
  logic [TOTAL_CONF_WIDTH-1:0]   shadow_conf_r;
  logic                          shadow_en_r;
  logic [TOTAL_CONF_WIDTH-1:0]   rx_conf_r;
  logic                          rx_en_r, cfg_ack_r, cfg_pending_r;
  logic                          apply_s, pending_next_s;

  logic                          done_d_r;
  logic                          push_s, pop_s, wr_en_s, ovf_set_s;
  logic [MAX_UART_DATA_W-1:0]    mem_r [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]         wr_ptr_r, rd_ptr_r;
  logic [FIFO_PTR_W:0]           count_r, count_next_s;
  logic                          rd_valid_r, fifo_full_r;
  logic                          overflow_r, parity_err_r, stop_err_r;

  // A write landing on the first edge after reset release is ignored
  assign cfg_wr_s = cfg_wr_i & init_done_r;

  // Config FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_OFF;
    else       state_r <= next_state_s;
  end

  // Config FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_OFF, ST_RUN: begin
        if (cfg_wr_s) next_state_s = ST_WAIT_IDLE;
        else          next_state_s = state_r;
      end
      ST_WAIT_IDLE: begin
        if (!rx_busy_i) next_state_s = ST_APPLY;
        else            next_state_s = ST_WAIT_IDLE;
      end
      // A write during APPLY must still be applied, so go back and wait
      ST_APPLY: begin
        if (cfg_wr_s)         next_state_s = ST_WAIT_IDLE;
        else if (shadow_en_r) next_state_s = ST_RUN;
        else                  next_state_s = ST_OFF;
      end
      default: next_state_s = ST_OFF;
    endcase
  end

  // Config FSM output decode
  always_comb begin
    apply_s        = 1'b0;
    pending_next_s = 1'b0;
    case (state_r)
      ST_APPLY: apply_s = 1'b1;
      default:  apply_s = 1'b0;
    endcase
    case (next_state_s)
      ST_WAIT_IDLE, ST_APPLY: pending_next_s = 1'b1;
      default:                pending_next_s = 1'b0;
    endcase
  end

  // Shadow registers and registered config outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_done_r   <= 1'b0;
      shadow_conf_r <= '0;
      shadow_en_r   <= 1'b0;
      rx_conf_r     <= '0;
      rx_en_r       <= 1'b0;
      cfg_ack_r     <= 1'b0;
      cfg_pending_r <= 1'b0;
    end else begin
      init_done_r   <= 1'b1;
      cfg_pending_r <= pending_next_s;
      cfg_ack_r     <= apply_s;
      if (cfg_wr_s) begin
        shadow_conf_r <= cfg_data_i;
        shadow_en_r   <= cfg_en_i;
      end
      if (apply_s) begin
        rx_conf_r <= shadow_conf_r;
        rx_en_r   <= shadow_en_r;
      end
    end
  end

  // FIFO control: a push into a full FIFO only succeeds alongside a pop
  always_comb begin
    push_s    = rx_done_i & ~done_d_r;
    pop_s     = rd_req_i & rd_valid_r;
    wr_en_s   = push_s & (~fifo_full_r | pop_s);
    ovf_set_s = push_s & fifo_full_r & ~pop_s;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, no reset needed as contents are qualified by rd_valid
  always_ff @(posedge clk_i) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= rx_data_i;
  end

  // FIFO pointers, occupancy, done edge register and sticky flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_d_r     <= 1'b0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      rd_valid_r   <= 1'b0;
      fifo_full_r  <= 1'b0;
      overflow_r   <= 1'b0;
      parity_err_r <= 1'b0;
      stop_err_r   <= 1'b0;
    end else begin
      done_d_r     <= rx_done_i;
      count_r      <= count_next_s;
      rd_valid_r   <= (count_next_s != '0);
      fifo_full_r  <= (count_next_s == DEPTH_C);
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      overflow_r   <= ovf_set_s | (overflow_r & ~clr_err_i);
      parity_err_r <= (push_s & rx_parity_err_i) | (parity_err_r & ~clr_err_i);
      stop_err_r   <= (push_s & rx_stop_err_i) | (stop_err_r & ~clr_err_i);
    end
  end

  assign cfg_pending_o = cfg_pending_r;
  assign cfg_ack_o     = cfg_ack_r;
  assign rx_en_o       = rx_en_r;
  assign rx_conf_o     = rx_conf_r;
  assign rd_valid_o    = rd_valid_r;
  assign rd_data_o     = mem_r[rd_ptr_r];
  assign fifo_count_o  = count_r;
  assign fifo_full_o   = fifo_full_r;
  assign overflow_o    = overflow_r;
  assign parity_err_o  = parity_err_r;
  assign stop_err_o    = stop_err_r;

endmodule

// File: tb/tb_rx_ctrl.sv
// Self-checking bench for rx_ctrl: directed config/reset scenarios plus a
// randomized FIFO/error phase checked by a queue scoreboard and flag model.
module tb_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [4:0] cfg_data;
  logic       cfg_en;
  logic       cfg_pending, cfg_ack, rx_en;
  logic [4:0] rx_conf;
  logic       rx_done, rx_busy, rx_parity_err, rx_stop_err;
  logic [7:0] rx_data;
  logic       rd_req, rd_valid;
  logic [7:0] rd_data;
  logic [3:0] fifo_count;
  logic       fifo_full, overflow, parity_err, stop_err, clr_err;

  rx_ctrl #(
    .MAX_UART_DATA_W (8),
    .TOTAL_CONF_WIDTH(5),
    .FIFO_DEPTH      (8),
    .FIFO_PTR_W      (3)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_wr_i       (cfg_wr),
    .cfg_data_i     (cfg_data),
    .cfg_en_i       (cfg_en),
    .cfg_pending_o  (cfg_pending),
    .cfg_ack_o      (cfg_ack),
    .rx_en_o        (rx_en),
    .rx_conf_o      (rx_conf),
    .rx_done_i      (rx_done),
    .rx_busy_i      (rx_busy),
    .rx_parity_err_i(rx_parity_err),
    .rx_stop_err_i  (rx_stop_err),
    .rx_data_i      (rx_data),
    .rd_req_i       (rd_req),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .fifo_count_o   (fifo_count),
    .fifo_full_o    (fifo_full),
    .overflow_o     (overflow),
    .parity_err_o   (parity_err),
    .stop_err_o     (stop_err),
    .clr_err_i      (clr_err)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_char(input logic [7:0] d, input logic pe, input logic se);
    rx_data       = d;
    rx_parity_err = pe;
    rx_stop_err   = se;
    rx_done       = 1'b1;
    tick();
    rx_done       = 1'b0;
    rx_parity_err = 1'b0;
    rx_stop_err   = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every accepted pop must present the oldest expected character
  always @(negedge clk) begin
    if (!rst && rd_req && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  int         pend_cnt, ack_cnt, ack_at, bad, hold, n;
  logic       popw, pe, se, clr, ovf_set, pushing;
  logic       m_ovf, m_par, m_stp;
  logic [7:0] d;

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_data = '0; cfg_en = 1'b0;
    rx_done = 1'b0; rx_busy = 1'b0; rx_parity_err = 1'b0; rx_stop_err = 1'b0;
    rx_data = '0; rd_req = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_rx_en", rx_en, 0);
    chk("rst_rx_conf", rx_conf, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_flags", {overflow, parity_err, stop_err}, 0);

    // config write coinciding with reset release is ignored
    rst = 1'b0; cfg_wr = 1'b1; cfg_data = 5'b10101; cfg_en = 1'b1;
    tick(); cfg_wr = 1'b0;
    tick();
    chk("rel_wr_pending", cfg_pending, 0);
    chk("rel_wr_rx_en", rx_en, 0);

    // basic apply with receiver idle
    cfg_wr = 1'b1; cfg_data = 5'b11011; cfg_en = 1'b1; rx_busy = 1'b0;
    pend_cnt = 0; ack_cnt = 0; ack_at = -1;
    tick(); cfg_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pend_cnt += int'(cfg_pending);
      ack_cnt  += int'(cfg_ack);
      if (cfg_ack) ack_at = i;
      tick();
    end
    chk("t1_pending_cycles", pend_cnt, 2);
    chk("t1_ack_count", ack_cnt, 1);
    chk("t1_ack_time", ack_at, 2);
    chk("t1_conf", rx_conf, 5'b11011);
    chk("t1_en", rx_en, 1);

    // deferred apply while busy, last write wins, one ack
    rx_busy = 1'b1; cfg_wr = 1'b1; cfg_data = 5'b00100; cfg_en = 1'b1;
    tick(); cfg_wr = 1'b0;
    bad = 0; ack_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rx_conf !== 5'b11011 || cfg_pending !== 1'b1) bad++;
      ack_cnt += int'(cfg_ack);
      if (i == 20) begin
        cfg_wr = 1'b1; cfg_data = 5'b01110; cfg_en = 1'b1;
      end else begin
        cfg_wr = 1'b0;
      end
      tick();
    end
    cfg_wr = 1'b0;
    chk("t2_hold_while_busy", bad, 0);
    rx_busy = 1'b0;
    tick();
    ack_cnt += int'(cfg_ack);
    chk("t2_apply_pending", cfg_pending, 1);
    chk("t2_conf_not_yet", rx_conf, 5'b11011);
    tick();
    ack_cnt += int'(cfg_ack);
    chk("t2_conf_applied", rx_conf, 5'b01110);
    chk("t2_ack_now", cfg_ack, 1);
    tick(); ack_cnt += int'(cfg_ack);
    tick(); ack_cnt += int'(cfg_ack);
    chk("t2_ack_count", ack_cnt, 1);
    chk("t2_pending_done", cfg_pending, 0);

    // long rx_done yields one push
    rx_data = 8'hA5; rx_done = 1'b1; exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) tick();
    rx_done = 1'b0;
    tick();
    chk("t3_count", fifo_count, 1);
    chk("t3_valid", rd_valid, 1);
    chk("t3_head", rd_data, 8'hA5);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("t3_count_after_pop", fifo_count, 0);
    chk("t3_valid_after_pop", rd_valid, 0);

    // fill past depth, then push+pop while full
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      push_char(8'(i), 1'b0, 1'b0);
    end
    chk("t4_full", fifo_full, 1);
    chk("t4_overflow", overflow, 1);
    chk("t4_count", fifo_count, 8);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t4_ovf_cleared", overflow, 0);
    rx_data = 8'h55; rx_done = 1'b1; rd_req = 1'b1; exp_q.push_back(8'h55);
    tick();
    rx_done = 1'b0; rd_req = 1'b0;
    chk("t4_pushpop_count", fifo_count, 8);
    chk("t4_pushpop_full", fifo_full, 1);
    chk("t4_pushpop_no_ovf", overflow, 0);
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rd_req = 1'b0;
    chk("t4_drained", fifo_count, 0);
    chk("t4_sb_empty", exp_q.size(), 0);

    // set beats clear in the same cycle
    clr_err = 1'b1; rx_data = 8'h77; rx_parity_err = 1'b1; rx_done = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    clr_err = 1'b0; rx_done = 1'b0; rx_parity_err = 1'b0;
    chk("t5_parity_set_wins", parity_err, 1);
    chk("t5_stop_clear", stop_err, 0);
    tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t5_parity_cleared", parity_err, 0);
    rd_req = 1'b1; tick(); rd_req = 1'b0;

    // randomized traffic against the queue/flag model
    m_ovf = 1'b0; m_par = 1'b0; m_stp = 1'b0; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_count", fifo_count, exp_q.size());
      chk("rnd_valid", rd_valid, exp_q.size() != 0);
      chk("rnd_full", fifo_full, exp_q.size() == 8);
      chk("rnd_overflow", overflow, m_ovf);
      chk("rnd_parity", parity_err, m_par);
      chk("rnd_stop", stop_err, m_stp);
      if (((c / 300) % 2) == 1) rd_req = ($urandom % 4) != 0;
      else                      rd_req = ($urandom % 8) == 0;
      n = exp_q.size();
      popw = rd_req && (n > 0);
      pushing = 1'b0; ovf_set = 1'b0; pe = 1'b0; se = 1'b0;
      if (hold > 0) begin
        hold--;
        rx_data = 8'($urandom);
        rx_parity_err = 1'($urandom);
        rx_stop_err = 1'($urandom);
      end else if (rx_done) begin
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        rx_parity_err = 1'($urandom);
        rx_stop_err = 1'($urandom);
      end else if (($urandom % 2) == 1) begin
        d = 8'($urandom);
        pe = ($urandom % 8) == 0;
        se = ($urandom % 8) == 0;
        rx_done = 1'b1; rx_data = d; rx_parity_err = pe; rx_stop_err = se;
        hold = int'($urandom_range(0, 3));
        pushing = 1'b1;
        if (n < 8 || popw) exp_q.push_back(d);
        else               ovf_set = 1'b1;
      end else begin
        rx_data = 8'($urandom);
        rx_parity_err = 1'($urandom);
        rx_stop_err = 1'($urandom);
      end
      clr = ($urandom % 20) == 0;
      clr_err = clr;
      m_ovf = ovf_set | (m_ovf & ~clr);
      m_par = (pushing & pe) | (m_par & ~clr);
      m_stp = (pushing & se) | (m_stp & ~clr);
      tick();
    end
    rx_done = 1'b0; rx_parity_err = 1'b0; rx_stop_err = 1'b0; clr_err = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rd_req = 1'b0;
    chk("rnd_drained", fifo_count, 0);
    chk("rnd_sb_empty", exp_q.size(), 0);

    // asynchronous reset in WAIT_IDLE with data in the FIFO
    rx_busy = 1'b1; cfg_wr = 1'b1; cfg_data = 5'b10001; cfg_en = 1'b0;
    tick(); cfg_wr = 1'b0;
    push_char(8'h11, 1'b1, 1'b0);
    push_char(8'h22, 1'b0, 1'b1);
    push_char(8'h33, 1'b0, 1'b0);
    chk("t6_pre_count", fifo_count, 3);
    chk("t6_pre_pending", cfg_pending, 1);
    chk("t6_pre_rx_en", rx_en, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rx_en", rx_en, 0);
    chk("t6_rx_conf", rx_conf, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_valid", rd_valid, 0);
    chk("t6_full", fifo_full, 0);
    chk("t6_flags", {overflow, parity_err, stop_err}, 0);
    chk("t6_pending", cfg_pending, 0);
    tick(); tick();
    rst = 1'b0; rx_busy = 1'b0;
    ack_cnt = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      ack_cnt += int'(cfg_ack);
      if (cfg_pending !== 1'b0 || rx_en !== 1'b0) bad++;
      tick();
    end
    chk("t6_no_ack", ack_cnt, 0);
    chk("t6_idle_after", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
- Control and buffering layer between the register/bus side and rx_module.
- Owns rx_en and the rx configuration word. Applies new configurations only while the receiver is not mid-character.
- Converts rx_done into single pushes into a show-ahead receive FIFO and keeps sticky error/overflow status for software.

Parameters:
MAX_UART_DATA_W, 8, width of received character
TOTAL_CONF_WIDTH, 5, width of rx configuration word {data[1:0], stop[1:0], parity_en}
FIFO_DEPTH, 8, number of FIFO entries (power of two)
FIFO_PTR_W, 3, log2(FIFO_DEPTH)

Ports:
clk_i  in  1  top clock
rst_i  in  1  reset; asynchronous, active-high
cfg_wr_i  in  1  1-cycle request to load cfg_data_i/cfg_en_i
cfg_data_i  in  TOTAL_CONF_WIDTH  requested rx configuration
cfg_en_i  in  1  requested receiver enable
cfg_pending_o  out  1  a config request is accepted but not yet applied
cfg_ack_o  out  1  1-cycle pulse when the config is applied
rx_en_o  out  1  to rx_module rx_en_i
rx_conf_o  out  TOTAL_CONF_WIDTH  to rx_module rx_conf_i
rx_done_i  in  1  from rx_module; may stay high for several clk cycles
rx_busy_i  in  1  from rx_module
rx_parity_err_i  in  1  from rx_module
rx_stop_err_i  in  1  from rx_module
rx_data_i  in  MAX_UART_DATA_W  from rx_module
rd_req_i  in  1  pop FIFO head
rd_valid_o  out  1  FIFO head valid (= not empty)
rd_data_o  out  MAX_UART_DATA_W  FIFO head (show-ahead)
fifo_count_o  out  FIFO_PTR_W+1  occupancy 0..FIFO_DEPTH
fifo_full_o  out  1  count == FIFO_DEPTH
overflow_o  out  1  sticky: character dropped because FIFO was full
parity_err_o  out  1  sticky parity error
stop_err_o  out  1  sticky stop error
clr_err_i  in  1  clears the three sticky flags

Behaviour:
- Reset (async, any time, including mid-character):
  - state OFF; rx_en_o=0, rx_conf_o=0.
  - cfg_pending_o=0, cfg_ack_o=0.
  - FIFO pointers and count = 0; rd_valid_o=0; fifo_full_o=0.
  - All sticky flags = 0; done edge register = 0; shadow registers = 0.
  - FIFO contents are discarded. rd_data_o is don't-care while rd_valid_o=0.
- Config FSM states: OFF, RUN, WAIT_IDLE, APPLY.
  - OFF/RUN + cfg_wr_i: latch cfg_data_i and cfg_en_i into shadow registers -> WAIT_IDLE.
  - WAIT_IDLE: rx_en_o and rx_conf_o hold their old values. -> APPLY when rx_busy_i=0 in that cycle.
  - APPLY (1 cycle): rx_conf_o<=shadow data, rx_en_o<=shadow enable, cfg_ack_o pulses on the next cycle. -> RUN if shadow enable=1, else OFF.
  - cfg_wr_i in WAIT_IDLE or APPLY overwrites the shadow registers (last write wins).
    - In WAIT_IDLE: no extra ack.
    - In APPLY: the new shadow value is not applied; the FSM returns to WAIT_IDLE instead of RUN/OFF.
  - cfg_pending_o=1 in WAIT_IDLE and APPLY.
  - cfg_wr_i in the same cycle as reset release is ignored.
- Done detection:
  - push = rx_done_i & ~rx_done_d, where rx_done_d is registered rx_done_i.
  - Exactly one push per rx_done_i high period, regardless of its length.
- FIFO:
  - push writes rx_data_i if not full.
  - Latency: push at edge N -> rd_valid_o/fifo_count_o updated after edge N.
  - Pop when rd_req_i & rd_valid_o; rd_req_i while empty is ignored.
  - Push while full with no pop: data dropped, overflow_o<=1, count stays FIFO_DEPTH.
  - Push and pop in the same cycle: both performed, count unchanged. This holds even when full, so no overflow in that case.
  - Pointers wrap modulo FIFO_DEPTH.
- Errors:
  - On push, parity_err_o |= rx_parity_err_i and stop_err_o |= rx_stop_err_i.
  - Characters with errors are still stored.
  - clr_err_i clears overflow_o, parity_err_o and stop_err_o.
  - If a set event occurs in the same cycle as clr_err_i, set wins.
- rx_done_i, error and data inputs are registered-domain signals from rx_module on the same clock; no synchronisers are needed.

Test Plan:
- Reset release, then cfg_wr_i with cfg_data_i=5'b11_01_1, cfg_en_i=1, rx_busy_i=0 -> WAIT_IDLE one cycle, APPLY, then rx_conf_o=5'b11011, rx_en_o=1, a single cfg_ack_o pulse, cfg_pending_o high for exactly 2 cycles.
- cfg_wr_i while rx_busy_i=1 for 40 cycles -> rx_conf_o unchanged and cfg_pending_o=1 throughout; apply occurs 1 cycle after rx_busy_i falls. A second cfg_wr_i mid-wait -> second value applied, one ack only.
- rx_done_i held high 16 cycles with rx_data_i=8'hA5 -> fifo_count_o=1, rd_data_o=8'hA5, rd_valid_o=1; rd_req_i one cycle -> count 0, rd_valid_o=0.
- Push 9 characters 8'h00..8'h08 with no reads (FIFO_DEPTH=8) -> fifo_full_o=1, overflow_o=1, reads return 8'h00..8'h07 in order. Then push and pop in the same cycle while full -> count stays 8, no data loss.
- Push with rx_parity_err_i=1 while clr_err_i is asserted in the same cycle -> parity_err_o=1. Next clr_err_i alone -> 0.
- Assert rst_i asynchronously mid-config (WAIT_IDLE) with 3 entries in the FIFO -> immediately rx_en_o=0, count=0, all flags 0, no cfg_ack_o after release.
